// File: rtl/fc_classifier_if.sv
// Feature stream and classification result bundle for fc_classifier.
// The slave modport is the classifier side; master drives features and observes results.
interface fc_classifier_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 10,
  parameter int ACC_W  = 24
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [3:0]               class_idx;
  logic signed [ACC_W-1:0]  max_score;
  logic [ACC_W*N_OUT-1:0]   scores_flat;

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, class_idx, max_score, scores_flat
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, class_idx, max_score, scores_flat
  );
endinterface

// File: rtl/fc_classifier.sv
// Fully-connected classifier: buffers one frame, runs one MAC per cycle over all weights, reports argmax.
// Result pulses N_IN*N_OUT+1 edges after the last feature; in_ready is low from last feature until the result edge.
module fc_classifier #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 48,
  parameter int N_OUT  = 10,
  parameter int ACC_W  = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_W*N_IN*N_OUT-1:0]    fc_weights_flat,
  fc_classifier_if.slave                  bus
);

  localparam int              CNT_W  = $clog2(N_IN);
  localparam int              WIDX_W = $clog2(N_IN*N_OUT);
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(N_IN-1);
  localparam logic [3:0]       LAST_C = 4'(N_OUT-1);

  typedef enum logic [1:0] {LOAD, MAC, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               c;
  logic signed [DATA_W-1:0] feat [N_IN];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  best_score;
  logic [3:0]               best_idx;
  logic                     out_valid_q;
  logic [3:0]               class_idx_q;
  logic signed [ACC_W-1:0]  max_score_q;
  logic [ACC_W*N_OUT-1:0]   scores_q;

  logic                       accept;
  logic                       last_i;
  logic [WIDX_W-1:0]          widx;
  logic signed [DATA_W-1:0]   w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;

  assign accept = (state == LOAD) && bus.in_valid;
  assign last_i = (cnt == LAST_I);

  // Weight w[c][i] lives at flat index c*N_IN+i; cnt doubles as i during MAC.
  assign widx     = WIDX_W'(32'(c) * N_IN + 32'(cnt));
  assign w_sel    = fc_weights_flat[DATA_W*widx +: DATA_W];
  assign prod     = feat[cnt] * w_sel;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (accept && last_i) state_nxt = MAC;
      MAC:     if (last_i && c == LAST_C) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Feature buffer needs no reset: every slot is rewritten before the next MAC pass.
  always_ff @(posedge clk) begin
    if (accept) feat[cnt] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      c           <= '0;
      acc         <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      out_valid_q <= 1'b0;
      class_idx_q <= '0;
      max_score_q <= '0;
      scores_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state)
        LOAD: begin
          if (accept) begin
            cnt <= last_i ? '0 : cnt + 1'b1;
            c   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          if (last_i) begin
            scores_q[ACC_W*c +: ACC_W] <= sum;
            // Strict compare keeps the lower index on ties.
            if (c == 4'd0 || sum > best_score) begin
              best_score <= sum;
              best_idx   <= c;
            end
            acc <= '0;
            cnt <= '0;
            c   <= c + 1'b1;
          end else begin
            acc <= sum;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          class_idx_q <= best_idx;
          max_score_q <= best_score;
          out_valid_q <= 1'b1;
          c           <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == LOAD);
  assign bus.out_valid   = out_valid_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.max_score   = max_score_q;
  assign bus.scores_flat = scores_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Directed/random bench for fc_classifier against a dot-product/argmax reference model.
module tb_fc_classifier;
  localparam int DATA_W = 8;
  localparam int N_IN   = 48;
  localparam int N_OUT  = 10;
  localparam int ACC_W  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W*N_IN*N_OUT-1:0] fc_weights_flat;

  always #5 clk = ~clk;

  fc_classifier_if #(.DATA_W(DATA_W), .N_OUT(N_OUT), .ACC_W(ACC_W)) bus ();

  fc_classifier #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fc_weights_flat(fc_weights_flat),
    .bus            (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int wt [N_OUT][N_IN];
  int feat [N_IN];
  int exp_score [N_OUT];
  int exp_idx;
  int exp_max;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_weights();
    for (int c = 0; c < N_OUT; c++)
      for (int i = 0; i < N_IN; i++)
        fc_weights_flat[DATA_W*(c*N_IN+i) +: DATA_W] = 8'(wt[c][i]);
  endtask

  task automatic random_weights();
    for (int c = 0; c < N_OUT; c++)
      for (int i = 0; i < N_IN; i++)
        wt[c][i] = int'($urandom_range(0, 255)) - 128;
    load_weights();
  endtask

  // Reference: plain dot products, first maximum wins.
  task automatic model();
    for (int c = 0; c < N_OUT; c++) begin
      int s = 0;
      for (int i = 0; i < N_IN; i++) s += feat[i] * wt[c][i];
      exp_score[c] = s;
    end
    exp_idx = 0;
    exp_max = exp_score[0];
    for (int c = 1; c < N_OUT; c++)
      if (exp_score[c] > exp_max) begin
        exp_max = exp_score[c];
        exp_idx = c;
      end
  endtask

  task automatic send_frame(input bit gaps, output int t_last);
    int idx = 0;
    int guard = 0;
    bit v, take;
    t_last = -1;
    while (idx < N_IN && guard < 2000) begin
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? 8'(feat[idx]) : 8'($urandom);
      take = v && bus.in_ready;
      @(posedge clk); #1;
      guard++;
      if (take) begin
        if (idx == N_IN - 1) t_last = cyc;
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    check("frame_accepted", idx, N_IN);
  endtask

  task automatic wait_result(input string tag, input int t_last, input bit hold);
    int first_vld = -1;
    int n_vld = 0;
    int first_rdy = -1;
    int k;
    while (cyc < t_last + 483) begin
      if (hold && cyc < t_last + 481) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      k = cyc - t_last;
      if (bus.out_valid === 1'b1) begin
        n_vld++;
        if (first_vld < 0) first_vld = k;
      end
      if (bus.in_ready === 1'b1 && first_rdy < 0) first_rdy = k;
    end
    bus.in_valid = 1'b0;
    check({tag, "_vld_edge"}, first_vld, 481);
    check({tag, "_vld_width"}, n_vld, 1);
    check({tag, "_rdy_edge"}, first_rdy, 481);
    check({tag, "_class_idx"}, 32'(bus.class_idx), exp_idx);
    check({tag, "_max_score"}, bus.max_score, exp_max);
    for (int c = 0; c < N_OUT; c++)
      check($sformatf("%s_score%0d", tag, c), $signed(bus.scores_flat[ACC_W*c +: ACC_W]), exp_score[c]);
  endtask

  task automatic run_frame(input string tag, input bit gaps, input bit hold);
    int t;
    model();
    send_frame(gaps, t);
    wait_result(tag, t, hold);
  endtask

  initial begin
    int t;
    int n_vld;
    int saved [N_IN];

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    random_weights();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_class_idx", 32'(bus.class_idx), 0);
    check("rst_max_score", bus.max_score, 0);
    check("rst_scores_zero", 32'(bus.scores_flat == '0), 1);

    foreach (feat[i]) feat[i] = 0;
    run_frame("zeros", 1'b0, 1'b0);

    foreach (feat[i]) feat[i] = 0;
    feat[0] = 1;
    run_frame("onehot0", 1'b0, 1'b0);

    foreach (feat[i]) feat[i] = 0;
    feat[1] = 1;
    run_frame("onehot1", 1'b0, 1'b0);

    foreach (feat[i]) feat[i] = int'($urandom_range(0, 255)) - 128;
    saved = feat;
    run_frame("gaps_hold", 1'b1, 1'b1);
    feat = saved;
    run_frame("nogaps", 1'b0, 1'b0);

    foreach (feat[i]) feat[i] = -128;
    for (int c = 0; c < N_OUT; c++)
      for (int i = 0; i < N_IN; i++) wt[c][i] = -128;
    load_weights();
    run_frame("extreme", 1'b0, 1'b0);
    check("extreme_no_overflow", exp_max, 786432);

    random_weights();
    foreach (feat[i]) feat[i] = int'($urandom_range(0, 255)) - 128;
    send_frame(1'b0, t);
    while (cyc < t + 199) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_class_idx", 32'(bus.class_idx), 0);
    check("midrst_max_score", bus.max_score, 0);
    check("midrst_scores_zero", 32'(bus.scores_flat == '0), 1);
    n_vld = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) n_vld++;
    end
    check("midrst_no_result", n_vld, 0);

    run_frame("after_rst", 1'b1, 1'b0);

    for (int r = 0; r < 2; r++) begin
      random_weights();
      foreach (feat[i]) feat[i] = int'($urandom_range(0, 255)) - 128;
      run_frame($sformatf("rand%0d", r), 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
